// File: rtl/seq_mult_param_if.sv
// seq_mult_param_if
//   Handshake and operand bundle for the sequential multiplier.
//   Parameters: WIDTH (operand width), RW (result width).
//   Signals:
//     start        request, sampled by the multiplier only while idle
//     signed_mode  1 = two's-complement operands, 0 = unsigned
//     multiplicand operand A
//     multiplier   operand B
//     acc_clr      (MULT_ACC_EN only) clear the running sum before adding
//     busy         operation in progress
//     done         one-cycle pulse, result valid from this cycle
//     result       product or running sum, held until the next done
//   Macro MULT_ACC_EN adds acc_clr.
//   master = requester, slave = multiplier.
interface seq_mult_param_if #(
  parameter int WIDTH = 8,
  parameter int RW    = 2 * WIDTH
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
`ifdef MULT_ACC_EN
  logic             acc_clr;
`endif
  logic             busy;
  logic             done;
  logic [RW-1:0]    result;

`ifdef MULT_ACC_EN
  modport master (output start, signed_mode, multiplicand, multiplier, acc_clr,
                  input  busy, done, result);
  modport slave  (input  start, signed_mode, multiplicand, multiplier, acc_clr,
                  output busy, done, result);
`else
  modport master (output start, signed_mode, multiplicand, multiplier,
                  input  busy, done, result);
  modport slave  (input  start, signed_mode, multiplicand, multiplier,
                  output busy, done, result);
`endif
endinterface

// File: rtl/seq_mult_param.sv
// seq_mult_param
//   Shift-add multiplier, one multiplier bit per clock. Signed or unsigned
//   operation is chosen per request. Takes WIDTH run cycles plus one idle
//   cycle per operation.
//   Parameters:
//     WIDTH  operand width, 2..32
//     ACC_W  result width when MULT_ACC_EN is defined
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    seq_mult_param_if.slave (start/operands in, busy/done/result out)
//   Macro MULT_ACC_EN: result becomes a wrapping running sum of products
//   (ACC_W bits), cleared before the add when acc_clr was set with start.
module seq_mult_param #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2 * WIDTH + 4
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_mult_param_if.slave  bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
`ifdef MULT_ACC_EN
  localparam int RW = ACC_W;
`else
  localparam int RW = PW;
  // ACC_W only sizes the result when accumulation is compiled in.
  localparam int unused_acc_w = ACC_W;
`endif

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [PW-1:0]    a_ext;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic [RW-1:0]    result_q;
`ifdef MULT_ACC_EN
  logic             clr_q;
  logic [RW-1:0]    prod_ext;
`endif

  logic             last;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The top bit of a signed multiplier weighs -2^(WIDTH-1), so its
  // partial product is subtracted instead of added.
  always_comb begin
    last = (cnt == CW'(WIDTH - 1));
    pp   = b[cnt] ? (a_ext << cnt) : '0;
    sum  = (last && mode) ? (acc - pp) : (acc + pp);
  end

`ifdef MULT_ACC_EN
  always_comb begin
    prod_ext = mode ? RW'($signed(sum)) : RW'(sum);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ext    <= '0;
      b        <= '0;
      mode     <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef MULT_ACC_EN
      clr_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode  <= bus.signed_mode;
            a_ext <= bus.signed_mode ? PW'($signed(bus.multiplicand))
                                     : PW'(bus.multiplicand);
            b     <= bus.multiplier;
            acc   <= '0;
            cnt   <= '0;
`ifdef MULT_ACC_EN
            clr_q <= bus.acc_clr;
`endif
          end
        end
        RUN: begin
          acc <= sum;
          cnt <= cnt + CW'(1);
          if (last) begin
            done_q <= 1'b1;
`ifdef MULT_ACC_EN
            result_q <= (clr_q ? '0 : result_q) + prod_ext;
`else
            result_q <= sum;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param
//   Directed vectors with hand-computed products for a WIDTH=8 and a WIDTH=4
//   multiplier. Expected results are queued when a request is issued; a
//   monitor per instance pops and compares on every done pulse and checks
//   that result otherwise holds its last value (0 after reset).
//   Builds with or without MULT_ACC_EN.
module tb_seq_mult_param;

  localparam int W8 = 8;
  localparam int W4 = 4;
`ifdef MULT_ACC_EN
  localparam bit ACC_EN = 1'b1;
  localparam int RW8    = 2 * W8 + 4;
  localparam int RW4    = 2 * W4 + 4;
`else
  localparam bit ACC_EN = 1'b0;
  localparam int RW8    = 2 * W8;
  localparam int RW4    = 2 * W4;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq_mult_param_if #(.WIDTH(W8), .RW(RW8)) bus8 ();
  seq_mult_param_if #(.WIDTH(W4), .RW(RW4)) bus4 ();

  seq_mult_param #(.WIDTH(W8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  seq_mult_param #(.WIDTH(W4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q8[$];
  string       name_q8[$];
  logic [63:0] exp_q4[$];
  string       name_q4[$];
  logic [63:0] acc8 = '0;
  logic [63:0] acc4 = '0;
  logic [63:0] held8 = '0;
  logic [63:0] held4 = '0;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected result register: product extended to rw bits, added to the
  // previous sum unless cleared (sum always restarts without accumulation).
  function automatic logic [63:0] model(input logic [63:0] prev,
                                        input logic [63:0] prod,
                                        input int pw, input int rw,
                                        input logic sm, input logic clr);
    logic [63:0] p;
    logic [63:0] base;
    p = prod & ((64'd1 << pw) - 64'd1);
    if (sm && p[pw-1]) p = p | ~((64'd1 << pw) - 64'd1);
    base = (ACC_EN && !clr) ? prev : 64'd0;
    return (base + p) & ((64'd1 << rw) - 64'd1);
  endfunction

  task automatic waitCycle();
    @(negedge clk);
    #1;
  endtask

  // Monitors: sample at the falling edge, away from the active edge.
  always @(negedge clk) begin : mon8
    string       n;
    logic [63:0] e;
    if (bus8.done) begin
      if (exp_q8.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done8: got done=1, expected no pending result");
      end else begin
        n = name_q8.pop_front();
        e = exp_q8.pop_front();
        checkOutput(n, 64'(bus8.result), e);
        held8 = e;
      end
    end else begin
      if (!rst_n) held8 = '0;
      checkOutput("hold8", 64'(bus8.result), held8);
    end
  end

  always @(negedge clk) begin : mon4
    string       n;
    logic [63:0] e;
    if (bus4.done) begin
      if (exp_q4.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done4: got done=1, expected no pending result");
      end else begin
        n = name_q4.pop_front();
        e = exp_q4.pop_front();
        checkOutput(n, 64'(bus4.result), e);
        held4 = e;
      end
    end else begin
      if (!rst_n) held4 = '0;
      checkOutput("hold4", 64'(bus4.result), held4);
    end
  end

  // One WIDTH=8 operation. glitch[k] raises start with different operands
  // and mode during run cycle k, which must be ignored.
  task automatic applyStimulus(input string name, input logic sm,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] prod, input logic clr,
                               input logic [15:0] glitch);
    int          cyc;
    int          busy_cyc;
    logic [63:0] exp;
    exp  = model(acc8, 64'(prod), 2 * W8, RW8, sm, clr);
    acc8 = exp;
    exp_q8.push_back(exp);
    name_q8.push_back(name);
    bus8.start        = 1'b1;
    bus8.signed_mode  = sm;
    bus8.multiplicand = a;
    bus8.multiplier   = b;
`ifdef MULT_ACC_EN
    bus8.acc_clr      = clr;
`endif
    waitCycle();
    bus8.start = 1'b0;
    cyc        = 1;
    busy_cyc   = 0;
    while (!bus8.done && cyc < 40) begin
      if (bus8.busy) busy_cyc++;
      if (cyc < 16 && glitch[cyc]) begin
        bus8.start        = 1'b1;
        bus8.signed_mode  = ~sm;
        bus8.multiplicand = 8'd9;
        bus8.multiplier   = 8'd9;
      end else begin
        bus8.start = 1'b0;
      end
      waitCycle();
      cyc++;
    end
    bus8.start = 1'b0;
    checkOutput({name, "_latency"}, 64'(cyc), 64'(W8 + 1));
    checkOutput({name, "_busy_cycles"}, 64'(busy_cyc), 64'(W8));
    checkOutput({name, "_busy_at_done"}, 64'(bus8.busy), 64'd0);
    waitCycle();
  endtask

  task automatic applyStimulusNarrow(input string name, input logic sm,
                                     input logic [3:0] a, input logic [3:0] b,
                                     input logic [7:0] prod);
    int          cyc;
    logic [63:0] exp;
    exp  = model(acc4, 64'(prod), 2 * W4, RW4, sm, 1'b1);
    acc4 = exp;
    exp_q4.push_back(exp);
    name_q4.push_back(name);
    bus4.start        = 1'b1;
    bus4.signed_mode  = sm;
    bus4.multiplicand = a;
    bus4.multiplier   = b;
`ifdef MULT_ACC_EN
    bus4.acc_clr      = 1'b1;
`endif
    waitCycle();
    bus4.start = 1'b0;
    cyc        = 1;
    while (!bus4.done && cyc < 40) begin
      waitCycle();
      cyc++;
    end
    checkOutput({name, "_latency"}, 64'(cyc), 64'(W4 + 1));
    waitCycle();
  endtask

  initial begin
    bus8.start = 1'b0; bus8.signed_mode = 1'b0;
    bus8.multiplicand = '0; bus8.multiplier = '0;
    bus4.start = 1'b0; bus4.signed_mode = 1'b0;
    bus4.multiplicand = '0; bus4.multiplier = '0;
`ifdef MULT_ACC_EN
    bus8.acc_clr = 1'b0;
    bus4.acc_clr = 1'b0;
`endif
    $display("[TB] seq_mult_param directed test, accumulate=%0d", ACC_EN);

    waitCycle();
    waitCycle();
    checkOutput("reset_busy8",   64'(bus8.busy),   64'd0);
    checkOutput("reset_done8",   64'(bus8.done),   64'd0);
    checkOutput("reset_result8", 64'(bus8.result), 64'd0);
    checkOutput("reset_busy4",   64'(bus4.busy),   64'd0);
    checkOutput("reset_result4", 64'(bus4.result), 64'd0);
    rst_n = 1'b1;
    waitCycle();

    applyStimulus("u_255x255",  1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 16'h0000);
    applyStimulus("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000, 1'b1, 16'h0000);
    applyStimulus("s_m1x127",   1'b1, 8'hFF, 8'h7F, 16'hFF81, 1'b1, 16'h0000);
    applyStimulus("s_5x0",      1'b1, 8'h05, 8'h00, 16'h0000, 1'b1, 16'h0000);
    applyStimulus("u_128x2",    1'b0, 8'h80, 8'h02, 16'h0100, 1'b1, 16'h0000);
    applyStimulus("s_127xm128", 1'b1, 8'h7F, 8'h80, 16'hC080, 1'b1, 16'h0000);
    // Extra start pulses in run cycle 4 and on the final run edge.
    applyStimulus("u_3x4_ignored_start", 1'b0, 8'h03, 8'h04, 16'h000C, 1'b1,
                  16'h0110);

    // Abort 7*7 in run cycle 4: no done, busy and result cleared.
    bus8.start = 1'b1; bus8.signed_mode = 1'b0;
    bus8.multiplicand = 8'd7; bus8.multiplier = 8'd7;
    waitCycle();
    bus8.start = 1'b0;
    repeat (3) waitCycle();
    checkOutput("abort_busy_before", 64'(bus8.busy), 64'd1);
    rst_n = 1'b0;
    acc8  = '0;
    acc4  = '0;
    waitCycle();
    checkOutput("abort_busy",   64'(bus8.busy),   64'd0);
    checkOutput("abort_result", 64'(bus8.result), 64'd0);
    rst_n = 1'b1;
    repeat (12) waitCycle();
    checkOutput("abort_idle", 64'(bus8.busy), 64'd0);
    applyStimulus("u_7x7_after_abort", 1'b0, 8'h07, 8'h07, 16'h0031, 1'b1,
                  16'h0000);

`ifdef MULT_ACC_EN
    applyStimulus("acc_3x4_clr", 1'b0, 8'h03, 8'h04, 16'h000C, 1'b1, 16'h0000);
    applyStimulus("acc_5x6_add", 1'b0, 8'h05, 8'h06, 16'h001E, 1'b0, 16'h0000);
    checkOutput("acc_running_sum", 64'(bus8.result), 64'd42);
    applyStimulus("acc_2x2_clr", 1'b0, 8'h02, 8'h02, 16'h0004, 1'b1, 16'h0000);
`endif

    applyStimulusNarrow("w4_s_7xm8",   1'b1, 4'h7, 4'h8, 8'hC8);
    applyStimulusNarrow("w4_u_15x15",  1'b0, 4'hF, 4'hF, 8'hE1);
    applyStimulusNarrow("w4_s_m8xm8",  1'b1, 4'h8, 4'h8, 8'h40);

    repeat (4) waitCycle();
    checkOutput("scoreboard_drained", 64'(exp_q8.size() + exp_q4.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_mult_param.md
Name:
seq_mult_param

Overview:
Parametrised sequential shift-add multiplier, one multiplier bit per clock. Successor to the fixed 8-bit state-per-bit multiplier. Adds:
- generic WIDTH
- signed/unsigned mode, selectable per operation
- start/busy/done handshake
- registered, held result

It is used as the multiply stage of the NN datapath (weight x activation) where area matters more than throughput.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32).
- ACC_W, 2*WIDTH+4, accumulator/result width when MULT_ACC_EN is defined; ignored otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- multiplicand  input  WIDTH  operand A; captured with start.
- multiplier  input  WIDTH  operand B; captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result valid from this cycle.
- result  output  RW  product (RW = 2*WIDTH, or ACC_W with MULT_ACC_EN); held until the next done.

Behaviour:
- Interface: one clock `clk`; reset is asynchronous and active-low, port `rst_n`.
- Reset (async assert, sync release): state IDLE; busy=0, done=0, result=0; internal registers 0.
- State IDLE:
  - When start=1 at an edge: capture operands and mode.
  - Multiplicand is extended to 2*WIDTH: sign-extended if signed_mode, else zero-extended.
  - Clear the working accumulator and set bit counter=0.
  - Go to RUN; busy=1 from the next cycle.
- State RUN, one edge per bit i = 0..WIDTH-1:
  - If B[i]=1, the partial product is A_ext<<i, computed modulo 2^(2*WIDTH).
  - For i = WIDTH-1 with signed_mode=1, the partial product is subtracted; all other cases add.
  - Counter increments each edge.
  - On the edge processing i = WIDTH-1: write the final sum to result, pulse done=1, set busy=0, return to IDLE.
- Latency: start sampled at edge E0; done high in the cycle after edge E0+WIDTH.
- Throughput: one operation per WIDTH+1 cycles.
- Any start is ignored while busy=1, including on the final RUN edge.
- start held high continuously gives back-to-back operations, each with a one-cycle IDLE gap.
- Operand and mode changes while busy have no effect.
- Reset mid-operation aborts the operation: no done, and result returns to 0.
- result changes only on the done edge or on reset.
- Arithmetic identities:
  - Unsigned: result = A*B exactly, 0..(2^WIDTH-1)^2.
  - Signed: result = A*B in two's complement 2*WIDTH bits. -2^(W-1) * -2^(W-1) = 2^(2W-2) fits.

Optional Feature:
- Macro: MULT_ACC_EN.
- Defined:
  - Adds input port acc_clr (1 bit), captured with start.
  - result widens to ACC_W.
  - On done: result <= (acc_clr_captured ? 0 : result) + sign/zero-extended product, wrapping modulo 2^ACC_W with no saturation.
  - Reset clears the running sum.
- Undefined: no acc_clr port; result = product only, width 2*WIDTH.

Test Plan:
- WIDTH=8, unsigned, A=255, B=255, start one cycle -> busy=1 for 8 cycles; done pulses in cycle 9 after the start edge; result=0xFE01.
- WIDTH=8, signed:
  - A=-128, B=-128 -> result=0x4000.
  - A=-1, B=127 -> result=0xFF81.
  - A=5, B=0 -> result=0.
- WIDTH=8: start A=3,B=4; pulse start again mid-run with A=9,B=9 -> exactly one done, result=12; busy is never extended.
- Assert rst_n=0 at RUN cycle 4 of A=7,B=7 -> busy=0, done never pulses, result=0; a fresh op 7*7 then gives 49.
- WIDTH=4, signed, A=7, B=-8 -> done in cycle 5 after the start edge; result=0xC8 (-56).
- MULT_ACC_EN, WIDTH=8, unsigned:
  - 3*4 with acc_clr=1 -> result=12.
  - Then 5*6 with acc_clr=0 -> result=42.
  - Then 2*2 with acc_clr=1 -> result=4.
